// File: rtl/prach_hb3_pair.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prach_hb3_pair                                                |
// | Purpose  : per-channel even/odd sample pairing ahead of the HB3 decimator |
// |            (optional sticky drop flag under PRACH_HB3_PAIR_ERR_EN)        |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module prach_hb3_pair #(
    parameter int WIDTH            = 16,
    parameter int NUM_CHANNEL      = 64,
    parameter int NUM_CHANNEL_USED = 48,
    parameter int LATENCY          = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_dq,
    input  logic             din_dv,
    input  logic [7:0]       din_chn,
    input  logic             sync_in,
    output logic [WIDTH-1:0] dout_dp1,
    output logic [WIDTH-1:0] dout_dp2,
    output logic             dout_dv,
    output logic [7:0]       dout_chn,
    output logic             sync_out
`ifdef PRACH_HB3_PAIR_ERR_EN
    ,
    output logic             err_drop
`endif
);

    localparam int                 c_CHN_W = $clog2(NUM_CHANNEL);
    localparam logic [c_CHN_W:0]   c_USED  = (c_CHN_W + 1)'(NUM_CHANNEL_USED);

    logic [NUM_CHANNEL-1:0] phase_q;
    logic [NUM_CHANNEL-1:0] phase_d;
    logic [WIDTH-1:0]       hold_mem [NUM_CHANNEL];

    logic                   fwd_vld_q;
    logic [c_CHN_W-1:0]     fwd_idx_q;
    logic [WIDTH-1:0]       fwd_dat_q;

    logic                   s1_vld_q;
    logic [WIDTH-1:0]       s1_even_q;
    logic [WIDTH-1:0]       s1_odd_q;
    logic [c_CHN_W-1:0]     s1_chn_q;

    logic                   out_vld_q;
    logic [WIDTH-1:0]       out_dp1_q;
    logic [WIDTH-1:0]       out_dp2_q;
    logic [c_CHN_W-1:0]     out_chn_q;

    logic [LATENCY-1:0]     sync_pipe_q;

    logic [c_CHN_W-1:0]     chn_idx;
    logic                   in_used;
    logic                   accept;
    logic                   cur_phase;
    logic [WIDTH-1:0]       hold_rd;
    logic                   unused_chn_hi;

    assign chn_idx       = din_chn[c_CHN_W-1:0];
    assign unused_chn_hi = ^din_chn[7:c_CHN_W];
    assign in_used       = ({1'b0, chn_idx} < c_USED);
    assign accept        = din_dv & in_used;
    // Sync realigns before the current sample is classified, so it lands as even.
    assign cur_phase     = sync_in ? 1'b0 : phase_q[chn_idx];
    assign hold_rd       = (fwd_vld_q && (fwd_idx_q == chn_idx)) ? fwd_dat_q
                                                                 : hold_mem[chn_idx];

    always_comb begin
        phase_d = sync_in ? '0 : phase_q;
        if (accept) begin
            phase_d[chn_idx] = ~cur_phase;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !cur_phase) begin
            hold_mem[chn_idx] <= din_dq;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q     <= '0;
            fwd_vld_q   <= 1'b0;
            fwd_idx_q   <= '0;
            fwd_dat_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_even_q   <= '0;
            s1_odd_q    <= '0;
            s1_chn_q    <= '0;
            out_vld_q   <= 1'b0;
            out_dp1_q   <= '0;
            out_dp2_q   <= '0;
            out_chn_q   <= '0;
            sync_pipe_q <= '0;
        end else begin
            phase_q     <= phase_d;
            fwd_vld_q   <= accept & ~cur_phase;
            fwd_idx_q   <= chn_idx;
            fwd_dat_q   <= din_dq;
            s1_vld_q    <= accept & cur_phase;
            if (accept && cur_phase) begin
                s1_even_q <= hold_rd;
                s1_odd_q  <= din_dq;
                s1_chn_q  <= chn_idx;
            end
            out_vld_q   <= s1_vld_q;
            if (s1_vld_q) begin
                out_dp1_q <= s1_odd_q;
                out_dp2_q <= s1_even_q;
                out_chn_q <= s1_chn_q;
            end
            sync_pipe_q <= {sync_pipe_q[LATENCY-2:0], sync_in};
        end
    end

    assign dout_dp1 = out_dp1_q;
    assign dout_dp2 = out_dp2_q;
    assign dout_dv  = out_vld_q;
    assign dout_chn = {{(8 - c_CHN_W){1'b0}}, out_chn_q};
    assign sync_out = sync_pipe_q[LATENCY-1];

`ifdef PRACH_HB3_PAIR_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n || sync_in) begin
            err_q <= 1'b0;
        end else if (din_dv && !in_used) begin
            err_q <= 1'b1;
        end
    end

    assign err_drop = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prach_hb3_pair.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_prach_hb3_pair                                             |
// | Purpose  : directed self-checking bench for prach_hb3_pair                |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_prach_hb3_pair;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din_dq = '0;
    logic        din_dv = 1'b0;
    logic [7:0]  din_chn = '0;
    logic        sync_in = 1'b0;
    logic [15:0] dout_dp1;
    logic [15:0] dout_dp2;
    logic        dout_dv;
    logic [7:0]  dout_chn;
    logic        sync_out;
`ifdef PRACH_HB3_PAIR_ERR_EN
    logic        err_drop;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prach_hb3_pair dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_dq   (din_dq),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dp1 (dout_dp1),
        .dout_dp2 (dout_dp2),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out)
`ifdef PRACH_HB3_PAIR_ERR_EN
        ,
        .err_drop (err_drop)
`endif
    );

    task automatic drive(input logic dv, input logic [7:0] chn,
                         input logic [15:0] dq, input logic sy);
        din_dv  = dv;
        din_chn = chn;
        din_dq  = dq;
        sync_in = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [41:0] got;
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        got = {dout_dv, dout_chn, dout_dp2, dout_dp1, sync_out};
        n_vec++;
        if (got !== 42'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", got, 42'h0);
        end
        rst_n = 1'b1;
        drive(1'b0, 8'd0, 16'h0, 1'b0);
    endtask

    task automatic test_basic();
        logic [40:0] got;
        drive(1'b1, 8'd5, 16'h0100, 1'b0);
        drive(1'b1, 8'd5, 16'h0200, 1'b0);
        n_vec++;
        if (dout_dv !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early_dv: got %b want 0", dout_dv);
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        got = {dout_dv, dout_chn, dout_dp2, dout_dp1};
        n_vec++;
        if (got !== {1'b1, 8'd5, 16'h0100, 16'h0200}) begin
            n_err++;
            $display("FAIL basic_pair: got %h want %h", got, {1'b1, 8'd5, 16'h0100, 16'h0200});
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        got = {dout_dv, dout_chn, dout_dp2, dout_dp1};
        n_vec++;
        if (got !== {1'b0, 8'd5, 16'h0100, 16'h0200}) begin
            n_err++;
            $display("FAIL basic_hold: got %h want %h", got, {1'b0, 8'd5, 16'h0100, 16'h0200});
        end
    endtask

    task automatic test_round_robin();
        logic [40:0] got;
        logic [40:0] exp;
        logic        pend;
        logic [7:0]  pch;
        logic [7:0]  pf;
        int          pairs;
        pend  = 1'b0;
        pch   = '0;
        pf    = '0;
        pairs = 0;
        drive(1'b0, 8'd0, 16'h0, 1'b1);
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        for (int f = 0; f < 4; f++) begin
            for (int ch = 0; ch < 64; ch++) begin
                drive(1'b1, 8'(ch), {8'(ch), 8'(f)}, 1'b0);
                pairs += int'(dout_dv);
                got = {dout_dv, dout_chn, dout_dp2, dout_dp1};
                exp = {1'b1, pch, pch, pf - 8'd1, pch, pf};
                n_vec++;
                if (pend && got !== exp) begin
                    n_err++;
                    $display("FAIL rr_pair f%0d ch%0d: got %h want %h", f, ch, got, exp);
                end else if (!pend && dout_dv !== 1'b0) begin
                    n_err++;
                    $display("FAIL rr_nodv f%0d ch%0d: got %b want 0", f, ch, dout_dv);
                end
                pend = (f % 2 == 1) && (ch < 48);
                pch  = 8'(ch);
                pf   = 8'(f);
            end
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        pairs += int'(dout_dv);
        n_vec++;
        if (pairs != 96) begin
            n_err++;
            $display("FAIL rr_pair_count: got %0d want 96", pairs);
        end
    endtask

    task automatic test_back_to_back();
        logic [40:0] got;
        drive(1'b1, 8'd7, 16'h1111, 1'b0);
        drive(1'b1, 8'd7, 16'h2222, 1'b0);
        drive(1'b1, 8'd7, 16'h3333, 1'b0);
        got = {dout_dv, dout_chn, dout_dp2, dout_dp1};
        n_vec++;
        if (got !== {1'b1, 8'd7, 16'h1111, 16'h2222}) begin
            n_err++;
            $display("FAIL b2b_pair1: got %h want %h", got, {1'b1, 8'd7, 16'h1111, 16'h2222});
        end
        drive(1'b1, 8'd7, 16'h4444, 1'b0);
        n_vec++;
        if (dout_dv !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: got %b want 0", dout_dv);
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        got = {dout_dv, dout_chn, dout_dp2, dout_dp1};
        n_vec++;
        if (got !== {1'b1, 8'd7, 16'h3333, 16'h4444}) begin
            n_err++;
            $display("FAIL b2b_pair2: got %h want %h", got, {1'b1, 8'd7, 16'h3333, 16'h4444});
        end
    endtask

    task automatic test_sync();
        logic [40:0] got;
        drive(1'b1, 8'd3, 16'h0AAA, 1'b0);
        drive(1'b0, 8'd0, 16'h0, 1'b1);
        n_vec++;
        if (sync_out !== 1'b0) begin
            n_err++;
            $display("FAIL sync_out_early: got %b want 0", sync_out);
        end
        drive(1'b1, 8'd3, 16'h0BBB, 1'b0);
        n_vec++;
        if (sync_out !== 1'b1) begin
            n_err++;
            $display("FAIL sync_out_pulse: got %b want 1", sync_out);
        end
        drive(1'b1, 8'd3, 16'h0CCC, 1'b0);
        n_vec++;
        if ({sync_out, dout_dv} !== 2'b00) begin
            n_err++;
            $display("FAIL sync_out_end: got %b want 00", {sync_out, dout_dv});
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        got = {dout_dv, dout_chn, dout_dp2, dout_dp1};
        n_vec++;
        if (got !== {1'b1, 8'd3, 16'h0BBB, 16'h0CCC}) begin
            n_err++;
            $display("FAIL sync_pair: got %h want %h", got, {1'b1, 8'd3, 16'h0BBB, 16'h0CCC});
        end
        // Sample arriving together with sync must restart as the even half.
        drive(1'b1, 8'd3, 16'h0123, 1'b0);
        drive(1'b1, 8'd3, 16'h0456, 1'b1);
        drive(1'b1, 8'd3, 16'h0789, 1'b0);
        n_vec++;
        if (dout_dv !== 1'b0) begin
            n_err++;
            $display("FAIL sync_same_cycle_dv: got %b want 0", dout_dv);
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        got = {dout_dv, dout_chn, dout_dp2, dout_dp1};
        n_vec++;
        if (got !== {1'b1, 8'd3, 16'h0456, 16'h0789}) begin
            n_err++;
            $display("FAIL sync_same_cycle_pair: got %h want %h", got, {1'b1, 8'd3, 16'h0456, 16'h0789});
        end
    endtask

    task automatic test_drop();
        logic [40:0] got;
        drive(1'b0, 8'd0, 16'h0, 1'b1);
`ifdef PRACH_HB3_PAIR_ERR_EN
        n_vec++;
        if (err_drop !== 1'b0) begin
            n_err++;
            $display("FAIL err_initial: got %b want 0", err_drop);
        end
`endif
        drive(1'b1, 8'd9, 16'h0909, 1'b0);
        drive(1'b1, 8'd50, 16'h5050, 1'b0);
`ifdef PRACH_HB3_PAIR_ERR_EN
        n_vec++;
        if (err_drop !== 1'b1) begin
            n_err++;
            $display("FAIL err_set: got %b want 1", err_drop);
        end
`endif
        drive(1'b1, 8'd50, 16'h5151, 1'b0);
        n_vec++;
        if (dout_dv !== 1'b0) begin
            n_err++;
            $display("FAIL drop_no_dv: got %b want 0", dout_dv);
        end
        drive(1'b1, 8'd9, 16'h0A0A, 1'b0);
        n_vec++;
        if (dout_dv !== 1'b0) begin
            n_err++;
            $display("FAIL drop_no_dv2: got %b want 0", dout_dv);
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        got = {dout_dv, dout_chn, dout_dp2, dout_dp1};
        n_vec++;
        if (got !== {1'b1, 8'd9, 16'h0909, 16'h0A0A}) begin
            n_err++;
            $display("FAIL drop_around_pair: got %h want %h", got, {1'b1, 8'd9, 16'h0909, 16'h0A0A});
        end
        // Tag bits above the channel index are ignored.
        drive(1'b1, 8'h45, 16'h4545, 1'b0);
        drive(1'b1, 8'hC5, 16'h5454, 1'b0);
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        got = {dout_dv, dout_chn, dout_dp2, dout_dp1};
        n_vec++;
        if (got !== {1'b1, 8'd5, 16'h4545, 16'h5454}) begin
            n_err++;
            $display("FAIL high_tag_bits: got %h want %h", got, {1'b1, 8'd5, 16'h4545, 16'h5454});
        end
`ifdef PRACH_HB3_PAIR_ERR_EN
        n_vec++;
        if (err_drop !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: got %b want 1", err_drop);
        end
        drive(1'b1, 8'd50, 16'h0, 1'b1);
        n_vec++;
        if (err_drop !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear_wins: got %b want 0", err_drop);
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0);
`endif
    endtask

    task automatic test_reset_mid();
        logic [41:0] got;
        drive(1'b1, 8'd9, 16'h0999, 1'b1);
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        got = {dout_dv, dout_chn, dout_dp2, dout_dp1, sync_out};
        n_vec++;
        if (got !== 42'h0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h want %h", got, 42'h0);
        end
        rst_n = 1'b1;
        drive(1'b1, 8'd9, 16'h0A0A, 1'b0);
        n_vec++;
        if ({sync_out, dout_dv} !== 2'b00) begin
            n_err++;
            $display("FAIL midreset_sync_pipe: got %b want 00", {sync_out, dout_dv});
        end
        drive(1'b1, 8'd9, 16'h0B0B, 1'b0);
        n_vec++;
        if (dout_dv !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_stale_pair: got %b want 0", dout_dv);
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0);
        got = {1'b0, dout_dv, dout_chn, dout_dp2, dout_dp1};
        n_vec++;
        if (got !== {1'b0, 1'b1, 8'd9, 16'h0A0A, 16'h0B0B}) begin
            n_err++;
            $display("FAIL midreset_pair: got %h want %h", got, {1'b0, 1'b1, 8'd9, 16'h0A0A, 16'h0B0B});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_back_to_back();
        test_sync();
        test_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
